// File: rtl/serial_cmp.sv
// Bit-serial MSB-first magnitude/equality comparator with early exit on the
// first differing bit, mode-selected result and a saturating match counter.
module serial_cmp #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             sgn,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic             clr_cnt,
  output logic             busy,
  output logic             done,
  output logic             out,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] MODE_EQ = 2'b00;
  localparam logic [1:0] MODE_LT = 2'b01;
  localparam logic [1:0] MODE_GT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       mode_q;
  logic             sgn_q;
  logic [IDX_W-1:0] idx;

  logic bit_a;
  logic bit_b;
  logic differ;
  logic a_wins;
  logic last_bit;
  logic finish;
  logic nxt_out;

  always_comb begin
    bit_a    = a_q[idx];
    bit_b    = b_q[idx];
    differ   = bit_a ^ bit_b;
    // The sign bit of a two's-complement operand carries negative weight.
    a_wins   = bit_a ^ (sgn_q & (idx == IDX_MSB));
    last_bit = (idx == '0);
    finish   = differ | last_bit;
    nxt_out  = 1'b0;
    case (mode_q)
      MODE_EQ: nxt_out = ~differ;
      MODE_LT: nxt_out = differ & ~a_wins;
      MODE_GT: nxt_out = differ & a_wins;
      default: nxt_out = differ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      sgn_q     <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      gt        <= 1'b0;
      match_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (clr_cnt) match_cnt <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q    <= IN1;
            b_q    <= IN2;
            mode_q <= mode;
            sgn_q  <= sgn;
            idx    <= IDX_MSB;
            busy   <= 1'b1;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (finish) begin
            eq    <= ~differ;
            lt    <= differ & ~a_wins;
            gt    <= differ & a_wins;
            out   <= nxt_out;
            done  <= 1'b1;
            state <= S_DONE;
            // A clear in the same cycle takes priority over the increment.
            if (!clr_cnt && nxt_out && (match_cnt != CNT_MAX))
              match_cnt <= match_cnt + CNT_W'(1);
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp.sv
// Scoreboarded bench for serial_cmp: stimulus pushes expected results computed
// with plain integer arithmetic; a monitor pops and compares on every done.
module tb_serial_cmp;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic             sgn;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             clr_cnt;
  logic             busy;
  logic             done;
  logic             out;
  logic             eq;
  logic             lt;
  logic             gt;
  logic [CNT_W-1:0] match_cnt;

  serial_cmp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .sgn(sgn),
    .IN1(in1), .IN2(in2), .clr_cnt(clr_cnt), .busy(busy), .done(done),
    .out(out), .eq(eq), .lt(lt), .gt(gt), .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic e;
    logic l;
    logic g;
    logic o;
    int   at;
    int   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cnt_m = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [1:0] m, input logic s,
                                output logic e, output logic l, output logic g,
                                output logic o, output int lat);
    int ai;
    int bi;
    if (s) begin
      ai = int'($signed(a));
      bi = int'($signed(b));
    end else begin
      ai = int'(a);
      bi = int'(b);
    end
    e = (ai == bi);
    l = (ai < bi);
    g = (ai > bi);
    case (m)
      2'b00:   o = e;
      2'b01:   o = l;
      2'b10:   o = g;
      default: o = !e;
    endcase
    lat = WIDTH + 1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        lat = WIDTH - i + 1;
        break;
      end
    end
  endfunction

  // clr_opt: 0 none, 1 clear while idle first, 2 clear on the DONE-entry edge,
  // 3 clear during the DONE cycle.
  task automatic do_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [1:0] m, input logic s, input int clr_opt);
    exp_t x;
    int   lat;
    int   s0;
    int   nc;
    if (clr_opt == 1) begin
      clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      cnt_m = 0;
    end
    model(a, b, m, s, x.e, x.l, x.g, x.o, lat);
    s0 = cyc;
    in1 = a; in2 = b; mode = m; sgn = s; start = 1'b1;
    nc = cnt_m + (x.o ? 1 : 0);
    if (nc > CNT_MAX) nc = CNT_MAX;
    if (clr_opt == 2) nc = 0;
    x.at = s0 + lat;
    x.cnt = nc;
    exp_q.push_back(x);
    cnt_m = (clr_opt == 3) ? 0 : nc;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_after_start", int'(busy), 1);
      // Junk on the inputs while busy must not disturb the running compare.
      start = ($urandom_range(0, 2) == 0);
      in1 = WIDTH'($urandom);
      in2 = WIDTH'($urandom);
      mode = 2'($urandom);
      sgn = 1'($urandom);
      clr_cnt = (clr_opt == 2 && k == lat - 1) || (clr_opt == 3 && k == lat);
    end
    @(negedge clk);
    start = 1'b0;
    clr_cnt = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
        chk("done_overdue", cyc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("done_cycle", cyc, x.at);
          chk("eq", int'(eq), int'(x.e));
          chk("lt", int'(lt), int'(x.l));
          chk("gt", int'(gt), int'(x.g));
          chk("out", int'(out), int'(x.o));
          chk("match_cnt", int'(match_cnt), x.cnt);
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int sel;
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; sgn = 1'b0;
    in1 = '0; in2 = '0; clr_cnt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'({busy, done, out, eq, lt, gt}), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmp(8'h00, 8'h0A, 2'b00, 1'b0, 0);
    do_cmp(8'h11, 8'h11, 2'b00, 1'b0, 0);
    do_cmp(8'h11, 8'h11, 2'b11, 1'b0, 0);
    do_cmp(8'h80, 8'h01, 2'b01, 1'b1, 0);
    do_cmp(8'h80, 8'h01, 2'b01, 1'b0, 0);
    for (int i = 0; i < 9; i++) do_cmp(8'h3C, 8'h3C, 2'b00, 1'b0, 0);
    do_cmp(8'h3C, 8'h3C, 2'b00, 1'b0, 3);
    do_cmp(8'h01, 8'h00, 2'b10, 1'b0, 2);

    // Reset in the middle of an equal compare: no done pulse, fresh start after.
    in1 = 8'h5A; in2 = 8'h5A; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", int'({busy, done, out, eq, lt, gt}), 0);
    chk("midrst_cnt", int'(match_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_m = 0;
    repeat (12) @(negedge clk);
    do_cmp(8'h10, 8'h20, 2'b10, 1'b0, 0);

    for (int n = 0; n < 250; n++) begin
      a = WIDTH'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0) b = a;
      else if (sel == 1) b = a ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      else b = WIDTH'($urandom);
      do_cmp(a, b, 2'($urandom), 1'($urandom), $urandom_range(0, 5));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_cmp.md
Name: serial_cmp

Overview:
- Parametrised, bit-serial magnitude/equality comparator; successor to the combinational 8-bit comparator.
- Latches two WIDTH-bit operands on start and scans them MSB-first, one bit per clock, with early exit on the first differing bit.
- Reports EQ/LT/GT flags and a mode-selected result with a done pulse.
- Keeps a saturating count of results where out=1; used as a low-area compare engine in lab datapaths.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- CNT_W, 8, width of match counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- mode  input  2  00=EQ, 01=LT, 10=GT, 11=NE (in1 relative to in2).
- sgn  input  1  1=two's-complement compare, 0=unsigned; latched with operands.
- IN1  input  WIDTH  operand A.
- IN2  input  WIDTH  operand B.
- clr_cnt  input  1  synchronous clear of match_cnt.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse when result valid.
- out  output  1  mode-selected result, held until next done.
- eq  output  1  A==B, held.
- lt  output  1  A<B, held.
- gt  output  1  A>B, held.
- match_cnt  output  CNT_W  number of completed compares with out=1, saturating.

Behaviour:
- One clock. Reset is asynchronous and active-low. While rst_n=0, all state and outputs are 0: busy, done, out, eq, lt, gt, match_cnt; FSM=IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on start=1, latch IN1, IN2, mode, sgn; set idx=WIDTH-1; go to SHIFT. start=0: stay.
- SHIFT: compare bit idx of the latched operands.
  - Bits differ: record the decision and go to DONE.
  - Unsigned: A bit=1 means gt; A bit=0 means lt.
  - sgn=1 and idx=WIDTH-1: sense is inverted (A bit=1 means lt).
  - Bits equal and idx=0: record eq and go to DONE.
  - Otherwise: idx decrements and the FSM stays in SHIFT.
- DONE lasts exactly one cycle:
  - done=1; eq/lt/gt/out are registered on entry and valid throughout DONE.
  - Exactly one of eq/lt/gt is 1.
  - out: EQ gives eq, LT gives lt, GT gives gt, NE gives ~eq.
  - Next state is always IDLE.
- Latency: start sampled at edge 0.
  - Highest differing bit i: done is high in cycle WIDTH-i+1.
  - Equal operands: done in cycle WIDTH+1.
  - Range 2..WIDTH+1.
- A new start is accepted in the cycle after DONE (IDLE). Back-to-back throughput is one compare per latency+1 cycles.
- start while busy=1 is ignored. It is not queued, and the latched operands are not disturbed.
- IN1/IN2/mode/sgn changes after start is accepted have no effect.
- Outputs out/eq/lt/gt hold their last values in IDLE and SHIFT. They change only on entry to DONE.
- match_cnt:
  - Increments by 1 on entry to DONE when the new out=1.
  - Saturates at 2^CNT_W-1.
  - clr_cnt=1 sets it to 0 on the next edge; clr_cnt wins over a simultaneous increment.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to IDLE with all outputs 0; no done pulse. The first start after release behaves as a fresh compare.

Test Plan:
- WIDTH=8, IN1=8'h00, IN2=8'h0A, mode=EQ, sgn=0, start at cycle 0 -> done only in cycle 6; out=0, lt=1, eq=0, gt=0; match_cnt stays 0.
- IN1=IN2=8'h11, mode=EQ -> done in cycle 9; eq=1, out=1, match_cnt=1. Repeat with mode=NE -> out=0, match_cnt stays 1.
- IN1=8'h80, IN2=8'h01, mode=LT, sgn=1 -> done in cycle 2, lt=1, out=1. Same operands with sgn=0 -> gt=1, out=0.
- Start with 8'h00/8'h00, then pulse start with 8'hFF/8'h00 in cycles 3 and 9 (busy) -> second request ignored; result eq=1 in cycle 9. Start in cycle 10 accepted -> gt=1 and done in cycle 12.
- CNT_W=2, five EQ compares of equal operands -> match_cnt=3 (saturated). clr_cnt=1 in the DONE cycle of a further match -> match_cnt=0.
- rst_n low in cycle 4 of a WIDTH=8 equal compare -> busy/done/flags 0 immediately, no done pulse. Release, then start IN1=8'h10, IN2=8'h20, mode=GT -> done in cycle 4 after start (bit 5 decides), lt=1, out=0.
